// File: rtl/bcd_conv_arbiter_if.sv
// Handshake bundle for the shared binary-to-BCD converter.
// It carries two requester channels, one result channel and a busy flag.
interface bcd_conv_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_id;
  logic        out_ovf;
  logic        busy;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
    output req0_ready, req1_ready, out_valid, out_data, out_id, out_ovf, busy
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, out_ready,
    input  req0_ready, req1_ready, out_valid, out_data, out_id, out_ovf, busy
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Two requesters share one iterative double-dabble engine, with round-robin grants.
// A result is produced 16 cycles after acceptance and held until the consumer takes it.
module bcd_conv_arbiter #(
  parameter bit SATURATE = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  bcd_conv_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]  state;
  logic [35:0] work;
  logic [35:0] adjusted;
  logic [35:0] work_next;
  logic [4:0]  count;
  logic        cur_id;
  logic        last_grant;
  logic        grant_idx;
  logic        accept;
  logic        ovf_next;
  logic [15:0] grant_data;

  // Ready is gated by reset_n so that reset forces both readys low at once.
  always_comb begin
    grant_idx  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
    grant_data = grant_idx ? bus.req1_data : bus.req0_data;
    accept     = reset_n && (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  end

  assign bus.req0_ready = accept && !grant_idx;
  assign bus.req1_ready = accept && grant_idx;
  assign bus.out_valid  = (state == DONE);
  assign bus.busy       = (state != IDLE);

  always_comb begin
    adjusted = work;
    for (int i = 0; i < 5; i++) begin
      if (work[16 + 4*i +: 4] >= 4'd5)
        adjusted[16 + 4*i +: 4] = work[16 + 4*i +: 4] + 4'd3;
    end
    work_next = adjusted << 1;
    ovf_next  = |work_next[35:32];
  end

  // Results are captured on the final shift, so they stay stable for the whole DONE stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      work         <= '0;
      count        <= '0;
      cur_id       <= 1'b0;
      last_grant   <= 1'b1;
      bus.out_data <= '0;
      bus.out_id   <= 1'b0;
      bus.out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            work       <= {20'b0, grant_data};
            cur_id     <= grant_idx;
            last_grant <= grant_idx;
            count      <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          work  <= work_next;
          count <= count + 5'd1;
          if (count == 5'd15) begin
            state        <= DONE;
            bus.out_data <= (ovf_next && SATURATE) ? 16'h9999 : work_next[31:16];
            bus.out_id   <= cur_id;
            bus.out_ovf  <= ovf_next;
          end
        end
        DONE: begin
          if (bus.out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: directed and random operands against a decimal-arithmetic model.
// A saturating and a non-saturating instance see identical stimulus.
module tb_bcd_conv_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  bit   last_m;

  bcd_conv_arbiter_if bus();
  bcd_conv_arbiter_if bus_raw();

  bcd_conv_arbiter #(.SATURATE(1'b1)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  bcd_conv_arbiter #(.SATURATE(1'b0)) dut_raw (.clk(clk), .reset_n(reset_n), .bus(bus_raw));

  assign bus_raw.req0_valid = bus.req0_valid;
  assign bus_raw.req0_data  = bus.req0_data;
  assign bus_raw.req1_valid = bus.req1_valid;
  assign bus_raw.req1_data  = bus.req1_data;
  assign bus_raw.out_ready  = bus.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int r;
    r = v % 10000;
    return {4'(r / 1000), 4'((r / 100) % 10), 4'((r / 10) % 10), 4'(r % 10)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v0, input logic [15:0] d0, input bit v1, input logic [15:0] d1);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input int v, input bit id);
    checkOutput({tag, "_data"}, bus.out_data, (v > 9999) ? 16'h9999 : to_bcd(v));
    checkOutput({tag, "_raw"}, bus_raw.out_data, to_bcd(v));
    checkOutput({tag, "_id"}, {15'b0, bus.out_id}, {15'b0, id});
    checkOutput({tag, "_ovf"}, {15'b0, bus.out_ovf}, {15'b0, v > 9999});
  endtask

  task automatic waitValid(input string tag);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      step();
      lat++;
    end
    checkOutput({tag, "_latency"}, 16'(lat), 16'd16);
  endtask

  // Called at posedge+1 with the engine idle; leaves the result sitting in DONE.
  task automatic sendOne(input string tag, input bit idx, input int v);
    applyStimulus(!idx, 16'(v), idx, 16'(v));
    #1;
    checkOutput({tag, "_ready"}, {14'b0, bus.req1_ready, bus.req0_ready}, idx ? 16'd2 : 16'd1);
    step();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    last_m = idx;
    waitValid(tag);
    checkResult(tag, v, idx);
  endtask

  task automatic finishOp(input string tag);
    step();
    checkOutput({tag, "_idle"}, {14'b0, bus.busy, bus.out_valid}, 16'd0);
  endtask

  initial begin
    int   seen;
    int   v;
    bit   idx;
    bit   exp_id;
    int   stall;
    checks = 0;
    errors = 0;
    last_m = 1'b1;
    reset_n = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 16'd5, 1'b1, 16'd7);

    #12;
    checkOutput("reset_ready", {14'b0, bus.req1_ready, bus.req0_ready}, 16'd0);
    checkOutput("reset_status", {14'b0, bus.busy, bus.out_valid}, 16'd0);
    checkOutput("reset_data", bus.out_data, 16'h0000);
    checkOutput("reset_id_ovf", {14'b0, bus.out_id, bus.out_ovf}, 16'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    reset_n = 1'b1;
    step();

    sendOne("r0_1234", 1'b0, 1234);
    checkOutput("r0_1234_busy", {15'b0, bus.busy}, 16'd1);
    finishOp("r0_1234");
    sendOne("r1_0", 1'b1, 0);
    finishOp("r1_0");
    sendOne("r1_9999", 1'b1, 9999);
    finishOp("r1_9999");
    sendOne("r0_65535", 1'b0, 65535);
    finishOp("r0_65535");

    // Hold the result in DONE while requesters shout; nothing may be accepted.
    sendOne("stall", 1'b1, 500);
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 16'h1111, 1'b1, 16'h2222);
    for (int k = 0; k < 5; k++) begin
      step();
      checkOutput("stall_valid", {15'b0, bus.out_valid}, 16'd1);
      checkOutput("stall_data", bus.out_data, 16'h0500);
      checkOutput("stall_ready", {14'b0, bus.req1_ready, bus.req0_ready}, 16'd0);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    bus.out_ready = 1'b1;
    finishOp("stall");

    // Abort mid-conversion; the reset must clear outputs asynchronously and emit nothing.
    applyStimulus(1'b1, 16'd4321, 1'b0, 16'h0);
    step();
    repeat (8) step();
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_status", {14'b0, bus.busy, bus.out_valid}, 16'd0);
    checkOutput("midrst_data", bus.out_data, 16'h0000);
    checkOutput("midrst_ready", {14'b0, bus.req1_ready, bus.req0_ready}, 16'd0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    step();
    reset_n = 1'b1;
    last_m = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.out_valid) seen++;
    end
    checkOutput("midrst_no_result", 16'(seen), 16'd0);

    // Continuous contention: grants alternate starting from req0 after reset.
    applyStimulus(1'b1, 16'd10, 1'b1, 16'd20);
    for (int k = 0; k < 4; k++) begin
      exp_id = ~last_m;
      #1;
      checkOutput("rr_ready", {14'b0, bus.req1_ready, bus.req0_ready}, exp_id ? 16'd2 : 16'd1);
      step();
      last_m = exp_id;
      waitValid("rr");
      checkResult("rr", exp_id ? 20 : 10, exp_id);
      step();
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0);
    step();

    for (int k = 0; k < 24; k++) begin
      idx = 1'($urandom_range(0, 1));
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535)) : int'($urandom_range(0, 9999));
      sendOne("rand", idx, v);
      stall = int'($urandom_range(0, 3));
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        repeat (stall) step();
        checkOutput("rand_hold", bus.out_data, (v > 9999) ? 16'h9999 : to_bcd(v));
        bus.out_ready = 1'b1;
      end
      finishOp("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
BCD_CONV_ARBITER -- requirements
Module: bcd_conv_arbiter

Interface
REQ-001 SHALL have parameter SATURATE, default 1, meaning: when 1, out-of-range inputs return 16'h9999; when 0, they return the low four BCD digits.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port req0_valid  input  1  requester 0 has a binary operand.
REQ-005 SHALL have port req0_data  input  16  requester 0 unsigned binary operand.
REQ-006 SHALL have port req0_ready  output  1  requester 0 operand accepted this cycle if valid.
REQ-007 SHALL have ports req1_valid / req1_data / req1_ready, identical to requester 0, for requester 1.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port out_data  output  16  packed BCD {thousands, hundreds, tens, ones}.
REQ-011 SHALL have port out_id  output  1  index of the requester that owns out_data.
REQ-012 SHALL have port out_ovf  output  1  operand was greater than 9999.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement an FSM with states IDLE, SHIFT and DONE, sharing one iterative double-dabble engine between two requesters.
REQ-015 IDLE: SHALL assert readyN combinationally only for the requester granted this cycle; at most one ready SHALL be high.
REQ-016 SHALL arbitrate round-robin: with both valid, grant the requester other than last_grant; with one valid, grant that one.
REQ-017 SHALL update last_grant to the granted index on acceptance (valid & ready); last_grant resets to 1, so req0 wins the first contention.
REQ-018 On acceptance SHALL load a 36-bit work register with {20'b0, data}, latch the id, clear the 5-bit iteration counter and go to SHIFT.
REQ-019 SHIFT: each cycle SHALL first add 3 to every 4-bit digit of bits [35:16] that is >= 5, then shift the whole register left by one and increment the counter.
REQ-020 SHALL leave SHIFT after exactly 16 shift cycles and enter DONE.
REQ-021 Latency: out_valid SHALL rise 16 cycles after the acceptance cycle; throughput SHALL be at most one operand per 18 cycles.
REQ-022 DONE: out_valid=1, with out_data, out_id and out_ovf registered and stable until out_valid & out_ready.
REQ-023 out_ovf SHALL be 1 iff the ten-thousands digit (bits [35:32]) is nonzero.
REQ-024 When out_ovf=1, out_data SHALL be 16'h9999 if SATURATE=1, else bits [31:16].
REQ-025 On out_valid & out_ready SHALL return to IDLE; a new acceptance SHALL NOT occur in that same cycle.
REQ-026 Requester valid/data changes during SHIFT or DONE SHALL be ignored; readyN SHALL stay 0 outside IDLE.
REQ-027 out_ready held low SHALL stall in DONE indefinitely with no loss or change of the result.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, busy=0, out_valid=0, out_data=0, out_id=0, out_ovf=0, req0_ready=0, req1_ready=0, counter=0 and last_grant=1.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result SHALL ever be emitted for it.
REQ-030 After reset_n deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-031 req0 sends 16'd1234, out_ready=1 -> out_valid 16 cycles later, out_data=16'h1234, out_id=0, out_ovf=0.
REQ-032 req1 sends 16'd0 -> out_data=16'h0000, out_id=1, out_ovf=0; then 16'd9999 -> 16'h9999, out_ovf=0.
REQ-033 req0 sends 16'd65535 -> out_ovf=1, out_data=16'h9999 with SATURATE=1, 16'h5535 with SATURATE=0.
REQ-034 Both requesters continuously valid (req0 = 16'd10, req1 = 16'd20) -> grants and results alternate 0,1,0,1, with out_data 16'h0010 and 16'h0020.
REQ-035 out_ready low for 5 cycles in DONE -> out_valid and out_data hold and both readys stay 0; out_ready high -> IDLE on the next cycle.
REQ-036 reset_n pulsed low at shift cycle 8 -> outputs immediately at reset values, no out_valid; next operand converts correctly.
